// File: rtl/mix_columns_ctrl.sv
// rtl/mix_columns_ctrl.sv - column-serial masked AES MixColumns controller with one shared column mixer

// Elements are redundant polynomials of degree < 8+d, decoded mod P = x^8+x^4+x^3+x+1.
// Arithmetic is carried out mod x^d*P so the width stays 8+d; refresh adds multiples of P.
module mix_column_single #(
    parameter int d = 2
) (
    input  logic [4*(8+d)-1:0] col,
    input  logic [d*d-1:0]     l_mat,
    input  logic [d-1:0]       b_ext,
    input  logic [15:0]        mc_sel,
    input  logic [16*d-1:0]    rnd,
    output logic [4*(8+d)-1:0] mixed
);
    localparam int N = 8 + d;
    localparam logic [N-1:0] P_N   = N'(9'h11b);
    localparam logic [N-1:0] Q_LOW = N'(8'h1b) << d;

    logic [N-1:0] a [4];
    logic [d-1:0] s [4];

    function automatic logic [N-1:0] xt(input logic [N-1:0] x);
        return {x[N-2:0], 1'b0} ^ (x[N-1] ? Q_LOW : '0);
    endfunction

    function automatic logic [d-1:0] lmul(input logic [d*d-1:0] m, input logic [d-1:0] r);
        logic [d-1:0] y;
        y = '0;
        for (int i = 0; i < d; i++) y[i] = ^(m[i*d +: d] & r);
        return y;
    endfunction

    function automatic logic [N-1:0] pmul(input logic [d-1:0] v);
        logic [N-1:0] acc;
        acc = '0;
        for (int i = 0; i < d; i++) if (v[i]) acc = acc ^ (P_N << i);
        return acc;
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_el
        assign a[k] = col[k*N +: N];
    end

    // Row j draws on refresh words 4j..4j+3; mc_sel picks which ones contribute.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            s[j] = b_ext;
            for (int k = 0; k < 4; k++)
                if (mc_sel[4*j+k]) s[j] = s[j] ^ lmul(l_mat, rnd[(4*j+k)*d +: d]);
        end
    end

    always_comb begin
        mixed = '0;
        for (int j = 0; j < 4; j++)
            mixed[j*N +: N] = xt(a[j]) ^ xt(a[(j+1)%4]) ^ a[(j+1)%4]
                            ^ a[(j+2)%4] ^ a[(j+3)%4] ^ pmul(s[j]);
    end
endmodule

module mix_columns_ctrl #(
    parameter int d = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*(8+d)-1:0] in_state,
    input  logic [d*d-1:0]      L,
    input  logic [d-1:0]        B_ext_MC,
    input  logic [15:0]         MC,
    input  logic                rnd_valid,
    output logic                rnd_ready,
    input  logic [16*d-1:0]     rnd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*(8+d)-1:0] out_state,
    output logic                busy,
    output logic [1:0]          col_idx
);
    localparam int N = 8 + d;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     fsm;
    logic [4*N-1:0] cols [4];
    logic [d*d-1:0] l_q;
    logic [d-1:0]   b_q;
    logic [15:0]    mc_q;
    logic [4*N-1:0] mixed;

    mix_column_single #(.d(d)) u_mix (
        .col    (cols[col_idx]),
        .l_mat  (l_q),
        .b_ext  (b_q),
        .mc_sel (mc_q),
        .rnd    (rnd_data),
        .mixed  (mixed)
    );

    // clr gates both handshakes so nothing is accepted or consumed in an abort cycle.
    assign in_ready  = (fsm == S_IDLE) && !clr;
    assign rnd_ready = (fsm == S_RUN) && rnd_valid && !clr;
    assign out_valid = (fsm == S_DONE);
    assign busy      = (fsm != S_IDLE);
    assign out_state = out_valid ? {cols[3], cols[2], cols[1], cols[0]} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= S_IDLE;
            col_idx <= 2'd0;
            l_q     <= '0;
            b_q     <= '0;
            mc_q    <= '0;
            for (int c = 0; c < 4; c++) cols[c] <= '0;
        end else if (clr) begin
            fsm     <= S_IDLE;
            col_idx <= 2'd0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < 4; c++) cols[c] <= in_state[c*4*N +: 4*N];
                        l_q     <= L;
                        b_q     <= B_ext_MC;
                        mc_q    <= MC;
                        col_idx <= 2'd0;
                        fsm     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rnd_valid) begin
                        cols[col_idx] <= mixed;
                        col_idx       <= col_idx + 2'd1;
                        if (col_idx == 2'd3) fsm <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) fsm <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_ctrl.sv
// tb/tb_mix_columns_ctrl.sv - self-checking bench for mix_columns_ctrl against a polynomial reference model
module tb_mix_columns_ctrl;
    localparam int D  = 2;
    localparam int N  = 8 + D;
    localparam logic [31:0] PA = 32'h11b;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [16*N-1:0]    in_state = '0;
    logic [D*D-1:0]     l_cfg = '0;
    logic [D-1:0]       b_cfg = '0;
    logic [15:0]        mc_cfg = '0;
    logic               rnd_valid = 1'b0;
    logic               rnd_ready;
    logic [16*D-1:0]    rnd_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [16*N-1:0]    out_state;
    logic               busy;
    logic [1:0]         col_idx;

    int n_checks = 0;
    int n_fail   = 0;

    mix_columns_ctrl #(.d(D)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .L(l_cfg), .B_ext_MC(b_cfg), .MC(mc_cfg),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy), .col_idx(col_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16*N-1:0] act, input logic [16*N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- reference model: plain polynomial arithmetic over GF(2) ----
    function automatic logic [31:0] clmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (b[i]) r = r ^ (a << i);
        return r;
    endfunction

    function automatic logic [31:0] pmod(input logic [31:0] a, input logic [31:0] m, input int deg);
        for (int i = 31; i >= deg; i--) if (a[i]) a = a ^ (m << (i - deg));
        return a;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [31:0] t;
        t = pmod(clmul(32'(a), 32'(b)), PA, 8);
        return t[7:0];
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p);
        logic [7:0] x [4];
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) x[j] = p[127-8*(4*c+j) -: 8];
            for (int j = 0; j < 4; j++)
                o[127-8*(4*c+j) -: 8] = gmul(8'h02, x[j]) ^ gmul(8'h03, x[(j+1)%4])
                                       ^ x[(j+2)%4] ^ x[(j+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] decode(input logic [16*N-1:0] s);
        logic [127:0] o;
        logic [31:0]  t;
        for (int e = 0; e < 16; e++) begin
            t = pmod(32'(s[e*N +: N]), PA, 8);
            o[127-8*e -: 8] = t[7:0];
        end
        return o;
    endfunction

    function automatic logic [16*N-1:0] encode(input logic [127:0] p);
        logic [16*N-1:0] s;
        logic [31:0]     m;
        for (int e = 0; e < 16; e++) begin
            m = clmul(PA, 32'($urandom_range(0, (1 << D) - 1)));
            s[e*N +: N] = N'(p[127-8*e -: 8]) ^ m[N-1:0];
        end
        return s;
    endfunction

    function automatic logic [31:0] exact_ref_el(input logic [16*N-1:0] s, input int c, input int j,
                                                 input logic [D*D-1:0] l, input logic [D-1:0] b,
                                                 input logic [15:0] mc, input logic [127:0] rw);
        logic [31:0] a [4];
        logic [D-1:0] sv, r, lr;
        logic [31:0] t;
        for (int k = 0; k < 4; k++) a[k] = 32'(s[(4*c+k)*N +: N]);
        sv = b;
        for (int k = 0; k < 4; k++) begin
            r = rw[c*32 + (4*j+k)*D +: D];
            for (int i = 0; i < D; i++) lr[i] = ^(l[i*D +: D] & r);
            if (mc[4*j+k]) sv = sv ^ lr;
        end
        t = clmul(32'h2, a[j]) ^ clmul(32'h3, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4] ^ clmul(PA, 32'(sv));
        return pmod(t, PA << D, N);
    endfunction

    function automatic logic [16*N-1:0] exact_ref(input logic [16*N-1:0] s, input logic [D*D-1:0] l,
                                                  input logic [D-1:0] b, input logic [15:0] mc,
                                                  input logic [127:0] rw);
        logic [16*N-1:0] o;
        logic [31:0] y;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                y = exact_ref_el(s, c, j, l, b, mc, rw);
                o[(4*c+j)*N +: N] = y[N-1:0];
            end
        return o;
    endfunction

    function automatic logic [16*N-1:0] junk();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full block: accept, feed rnd with an optional stall, hold DONE, release.
    task automatic run_block(input logic [127:0] plain, input logic [127:0] exp_dec,
                             input int stall_col, input int stall_len, input int hold_len);
        logic [16*N-1:0] enc, got, expx;
        logic [D*D-1:0] l; logic [D-1:0] b; logic [15:0] mc;
        logic [127:0] rw;
        int lat, hs, widx, stalled;
        logic hs_now;
        enc = encode(plain);
        l = D*D'($urandom); b = D'($urandom); mc = 16'($urandom);
        rw = {$urandom, $urandom, $urandom, $urandom};
        expx = exact_ref(enc, l, b, mc, rw);
        @(negedge clk);
        in_valid = 1'b1; in_state = enc; l_cfg = l; b_cfg = b; mc_cfg = mc;
        #1 check("in_ready_idle", 160'(in_ready), 160'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_state = junk(); l_cfg = D*D'($urandom); b_cfg = D'($urandom); mc_cfg = 16'($urandom);
        lat = 0; hs = 0; widx = 0; stalled = 0;
        while (!out_valid && lat < 40) begin
            if (widx == stall_col && stalled < stall_len) begin
                rnd_valid = 1'b0; stalled++;
            end else rnd_valid = 1'b1;
            rnd_data = (widx < 4) ? rw[widx*32 +: 32] : $urandom;
            #1;
            if (!rnd_valid) begin
                check("stall_rnd_ready", 160'(rnd_ready), 160'(0));
                check("stall_col_idx", 160'(col_idx), 160'(widx));
            end
            hs_now = rnd_valid && rnd_ready;
            @(posedge clk);
            if (hs_now) begin hs++; widx++; end
            lat++;
            #1;
        end
        rnd_valid = 1'b0;
        check("latency", 160'(lat), 160'(4 + stall_len));
        got = out_state;
        for (int h = 0; h < hold_len; h++) begin
            in_valid = 1'b1; in_state = junk();
            #1;
            check("hold_in_ready", 160'(in_ready), 160'(0));
            check("hold_out_state", out_state, got);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 check("done_out_valid", 160'(out_valid), 160'(1));
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_done", {out_state, busy, out_valid}, '0);
        check("exact_state", got, expx);
        check("decoded_state", 160'(decode(got)), 160'(exp_dec));
        check("rnd_handshakes", 160'(hs), 160'(4));
    endtask

    typedef struct {
        logic [127:0] plain;
        logic [127:0] dec;
        int stall_col;
        int stall_len;
        int hold_len;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [127:0] p;
        tbl[0] = '{{4{32'hdb135345}}, {4{32'h8e4da1bc}}, -1, 0, 0};
        tbl[1] = '{128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5,
                   128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6, 2, 3, 0};
        tbl[2] = '{{4{32'hdb135345}}, {4{32'h8e4da1bc}}, -1, 0, 5};
        tbl[3] = '{128'h2d26314c_db135345_01010101_f20a225c,
                   128'h4d7ebdf8_8e4da1bc_01010101_9fdc589d, 0, 1, 2};

        // reset state
        rnd_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {out_state, out_valid, busy, col_idx, rnd_ready}, '0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("reset_release", {159'(0), in_ready}, 160'(1));
        check("reset_rnd_ready", 160'(rnd_ready), 160'(0));
        rnd_valid = 1'b0;

        for (int i = 0; i < 4; i++)
            run_block(tbl[i].plain, tbl[i].dec, tbl[i].stall_col, tbl[i].stall_len, tbl[i].hold_len);

        // clr at column 2
        @(negedge clk);
        in_valid = 1'b1; in_state = encode({4{32'hdb135345}});
        @(posedge clk); #1;
        in_valid = 1'b0; rnd_valid = 1'b1; rnd_data = $urandom;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_clr_col_idx", 160'(col_idx), 160'(2));
        clr = 1'b1;
        #1 check("clr_rnd_ready", 160'(rnd_ready), 160'(0));
        check("clr_in_ready", 160'(in_ready), 160'(0));
        @(posedge clk); #1;
        clr = 1'b0; rnd_valid = 1'b0;
        check("after_clr", {out_state, out_valid, busy, col_idx}, '0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        in_valid = 1'b1; in_state = encode({4{32'h01010101}});
        @(posedge clk); #1;
        in_valid = 1'b0; rnd_valid = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check("async_reset", {out_state, out_valid, busy, col_idx}, '0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_reset_rnd_ready", 160'(rnd_ready), 160'(0));
        rnd_valid = 1'b0;

        run_block(tbl[0].plain, tbl[0].dec, -1, 0, 0);

        // randomized blocks against the model
        for (int i = 0; i < 12; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(p, aes_ref(p), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mix_columns_ctrl.md
MIX_COLUMNS_CTRL -- requirements
Module: mix_columns_ctrl

Interface
REQ-001 SHALL have parameter d, default d (package value), meaning code redundancy; element width N = 8+d bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous abort to IDLE.
REQ-005 SHALL have port in_valid  input  1  input state offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a state.
REQ-007 SHALL have port in_state  input  16*N  masked state as four state_word_t columns; column c = elements 4c..4c+3.
REQ-008 SHALL have port L  input  mm_matrix_t  mixer config, sampled on accept.
REQ-009 SHALL have port B_ext_MC  input  mc_m_matrix_t  mixer config, sampled on accept.
REQ-010 SHALL have port MC  input  mn_matrix_t  mixer config, sampled on accept.
REQ-011 SHALL have port rnd_valid  input  1  fresh randomness available.
REQ-012 SHALL have port rnd_ready  output  1  randomness consumed this cycle.
REQ-013 SHALL have port rnd_data  input  red_poly_t[0:15]  16 refresh polynomials for one column.
REQ-014 SHALL have port out_valid  output  1  result state held.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have port out_state  output  16*N  mixed masked state, same layout as in_state.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.
REQ-018 SHALL have port col_idx  output  2  column being processed.

Function
REQ-019 SHALL instantiate exactly one mix_column_single, shared across all four columns, fed from the state buffer column col_idx, registered L/B_ext_MC/MC and rnd_data.
REQ-020 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-021 IDLE: in_ready=1; on in_valid&&in_ready, load in_state into the buffer, register L/B_ext_MC/MC, set col_idx=0, go to RUN.
REQ-022 RUN: rnd_ready = rnd_valid; on rnd_valid, write mixer output over buffer column col_idx and increment col_idx; with rnd_valid low, hold all registers.
REQ-023 RUN with col_idx=3 and rnd_valid: write column 3, go to DONE, col_idx wraps to 0.
REQ-024 DONE: out_valid=1 and out_state=buffer, stable while out_ready is low; on out_ready go to IDLE.
REQ-025 in_ready SHALL be 0 outside IDLE; no new state is accepted in the DONE->IDLE transition cycle.
REQ-026 Latency: with rnd_valid held high, out_valid SHALL rise 4 cycles after the accept edge.
REQ-027 rnd_ready SHALL be 0 outside RUN; each rnd_data word is used for exactly one column and never reused.
REQ-028 clr SHALL take priority over every transition: next state IDLE, col_idx=0, no rnd consumed that cycle, out_valid=0 next cycle.
REQ-029 out_state SHALL be 0 whenever out_valid=0, so partial results are not exposed.
REQ-030 Unmasked, each output column SHALL equal the AES MixColumns of the decoded input column.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, col_idx=0, in_ready=1 after release, rnd_ready=0, out_valid=0, busy=0, buffer and config registers 0.
REQ-032 Reset asserted mid-RUN or in DONE SHALL discard the state; rnd_ready SHALL be 0 in the first cycle after release.

Verification
REQ-033 Column db 13 53 45 (all columns), rnd_valid=1, out_ready=1 -> out_valid 4 cycles after accept; decoded columns 8e 4d a1 bc.
REQ-034 Columns f2 0a 22 5c / 01 01 01 01 / c6 c6 c6 c6 / d4 d4 d4 d5 -> decoded 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6 / d5 d5 d7 d6.
REQ-035 rnd_valid low for 3 cycles before column 2 -> col_idx holds at 2; rnd_ready=0 for those cycles; result unchanged; 7-cycle latency.
REQ-036 out_ready low for 5 cycles in DONE -> out_state stable, in_ready=0 throughout; in_valid ignored until IDLE.
REQ-037 clr at col_idx=2, then rst_n pulse in a new RUN -> IDLE with col_idx=0 each time; next block result correct; rnd handshake count = 4 per completed block.
